// File: rtl/burst_read_master_pkg.sv
// Shared definitions for the burst read master.
//   state_t : controller state (IDLE waits for go, ISSUE presents bursts,
//             DRAIN waits for outstanding words to come back)
//   clog2   : ceiling log2, used for elaboration-time width checks
package burst_read_master_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rm_showahead_fifo.sv
// Show-ahead (first-word-fall-through) FIFO for the burst read master.
// The head word is presented combinationally from storage on rdata; a word
// written at an edge is visible from the following cycle (no write bypass).
//   clk, reset : clock, asynchronous active-high reset (clears pointers/count)
//   wr, wdata  : push request and data; dropped only if full without a pop
//   rd         : pop the head word; ignored while empty
//   rdata      : current head word
//   empty/full : status flags
//   used       : number of stored words, wide enough to hold DEPTH itself
module rm_showahead_fifo
    import burst_read_master_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    localparam int DEPTH_LOG2 = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  rd,
    output logic [WIDTH-1:0]      rdata,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   used
);

    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  rd_en;
    logic                  wr_en;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);
    assign used  = count;
    assign rdata = mem[rd_ptr];

    // A pop in the same cycle frees a slot, so push-while-full is legal then.
    assign rd_en = rd & ~empty;
    assign wr_en = wr & (~full | rd_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/burst_read_master.sv
// Burst-capable Avalon-MM read master feeding a show-ahead FIFO.
// Reads control_read_length bytes starting at control_read_base, issuing
// bursts of up to MAXBURST words aligned to MAXBURST-word boundaries (or
// always at the base address in fixed-location mode). FIFO space for a whole
// burst is reserved before the command is presented, so returned data can
// always be written.
//
// Ports
//   clk, reset              : clock, asynchronous active-high reset
//   control_fixed_location  : sampled on go; 1 keeps the address constant
//   control_read_base       : start byte address (word aligned)
//   control_read_length     : byte count; sub-word bits ignored
//   control_go              : start pulse, honoured only while idle
//   control_abort           : stop issuing further bursts, drain the rest
//   control_busy            : high whenever not idle
//   control_done            : one-cycle pulse on return to idle
//   user_read_buffer        : pop the FIFO head
//   user_buffer_data        : FIFO head word
//   user_data_available     : FIFO not empty
//   master_*                : Avalon-MM burst read master (registered outputs)
//
// Command handshake: a command is transferred at a rising edge where
// master_read is high and master_waitrequest is low. While master_read is
// high and master_waitrequest is high the command (address, burstcount) is
// held unchanged; master_read is never withdrawn once raised.
module burst_read_master
    import burst_read_master_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURST        = 8,
    parameter int MAXBURST_LOG2   = 3,
    parameter int FIFODEPTH       = 64,
    parameter int FIFODEPTH_LOG2  = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_read_base,
    input  logic [ADDRESSWIDTH-1:0]    control_read_length,
    input  logic                       control_go,
    input  logic                       control_abort,
    output logic                       control_busy,
    output logic                       control_done,
    input  logic                       user_read_buffer,
    output logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_data_available,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_read,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [MAXBURST_LOG2:0]     master_burstcount,
    input  logic [DATAWIDTH-1:0]       master_readdata,
    input  logic                       master_readdatavalid,
    input  logic                       master_waitrequest
);

    localparam int BE_LOG2 = clog2(BYTEENABLEWIDTH);
    localparam int AW      = ADDRESSWIDTH;
    localparam int BW      = MAXBURST_LOG2 + 1;
    localparam int PW      = FIFODEPTH_LOG2 + 1;
    localparam int SW      = FIFODEPTH_LOG2 + 2;

    // Elaboration-time parameter checks.
    if (BYTEENABLEWIDTH * 8 != DATAWIDTH) begin : g_bad_byteenable
        $error("BYTEENABLEWIDTH must equal DATAWIDTH/8");
    end
    if ((1 << BE_LOG2) != BYTEENABLEWIDTH) begin : g_bad_be_pow2
        $error("BYTEENABLEWIDTH must be a power of 2");
    end
    if (MAXBURST < 1 || (1 << MAXBURST_LOG2) != MAXBURST) begin : g_bad_maxburst
        $error("MAXBURST must be a power of 2 and equal 2**MAXBURST_LOG2");
    end
    if ((1 << FIFODEPTH_LOG2) != FIFODEPTH) begin : g_bad_fifodepth
        $error("FIFODEPTH must be a power of 2 and equal 2**FIFODEPTH_LOG2");
    end
    if (FIFODEPTH < 2 * MAXBURST) begin : g_bad_fifo_vs_burst
        $error("FIFODEPTH must be at least 2*MAXBURST");
    end

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     words;
    logic              fixed;
    logic [PW-1:0]     pending;
    logic              abort_req;

    logic [AW-1:0]     go_words;
    logic [AW-1:0]     cand_address;
    logic [AW-1:0]     cand_words;
    logic              cand_fixed;
    logic [BW-1:0]     burst_next;
    logic [BW-1:0]     acc_words;
    logic [PW-1:0]     pending_next;
    logic [PW-1:0]     used_next;
    logic              space_ok;
    logic              accept;
    logic              pop_eff;
    logic              push_eff;

    logic              read_next;
    logic [BW-1:0]     count_next;
    logic              done_next;
    logic              abort_next;

    logic [PW-1:0]     fifo_used;
    logic              fifo_empty;
    logic              fifo_full;

    // Words in the next burst: up to the next MAXBURST-word boundary in
    // normal mode, a plain MAXBURST cap in fixed mode, never past the end.
    function automatic logic [BW-1:0] burst_size(input logic [AW-1:0] addr,
                                                 input logic [AW-1:0] nwords,
                                                 input logic          fix);
        logic [AW-1:0] offset;
        logic [AW-1:0] limit;
        offset = (addr >> BE_LOG2) & AW'(MAXBURST - 1);
        limit  = fix ? AW'(MAXBURST) : AW'(MAXBURST) - offset;
        return (nwords < limit) ? BW'(nwords) : BW'(limit);
    endfunction

    assign go_words            = control_read_length >> BE_LOG2;
    assign accept              = master_read & ~master_waitrequest;
    assign acc_words           = accept ? master_burstcount : '0;
    assign control_busy        = (state != IDLE);
    assign master_byteenable   = '1;
    assign user_data_available = ~fifo_empty;

    // Exact next-cycle occupancy so a new burst can be presented right after
    // an acceptance without a bubble.
    assign pop_eff      = user_read_buffer & ~fifo_empty;
    assign push_eff     = master_readdatavalid & (~fifo_full | pop_eff);
    assign pending_next = pending + PW'(acc_words) - PW'(master_readdatavalid);
    assign used_next    = fifo_used + PW'(push_eff) - PW'(pop_eff);

    // Values the address/words/fixed registers take at the coming edge.
    always_comb begin
        cand_address = master_address;
        cand_words   = words;
        cand_fixed   = fixed;
        if (state == IDLE) begin
            if (control_go) begin
                cand_address = control_read_base;
                cand_words   = go_words;
                cand_fixed   = control_fixed_location;
            end
        end else if (accept) begin
            cand_words = words - AW'(master_burstcount);
            if (!fixed) begin
                cand_address = master_address + (AW'(master_burstcount) << BE_LOG2);
            end
        end
    end

    assign burst_next = burst_size(cand_address, cand_words, cand_fixed);
    assign space_ok   = (SW'(used_next) + SW'(pending_next) + SW'(burst_next))
                        <= SW'(FIFODEPTH);

    always_comb begin
        state_next = state;
        read_next  = master_read;
        count_next = master_burstcount;
        done_next  = 1'b0;
        abort_next = abort_req;
        case (state)
            IDLE: begin
                abort_next = 1'b0;
                read_next  = 1'b0;
                if (control_go) begin
                    if (go_words == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = ISSUE;
                        read_next  = space_ok;
                        count_next = burst_next;
                    end
                end
            end
            ISSUE: begin
                // Abort is remembered so a stalled command can finish first.
                if (control_abort) begin
                    abort_next = 1'b1;
                end
                if (accept && cand_words == '0) begin
                    state_next = DRAIN;
                    read_next  = 1'b0;
                end else if (master_read && !accept) begin
                    read_next = 1'b1;
                end else if (control_abort || abort_req) begin
                    state_next = DRAIN;
                    read_next  = 1'b0;
                end else begin
                    read_next = space_ok;
                    if (space_ok) begin
                        count_next = burst_next;
                    end
                end
            end
            DRAIN: begin
                read_next = 1'b0;
                if (pending == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            master_address    <= '0;
            master_read       <= 1'b0;
            master_burstcount <= '0;
            control_done      <= 1'b0;
            words             <= '0;
            fixed             <= 1'b0;
            pending           <= '0;
            abort_req         <= 1'b0;
        end else begin
            state             <= state_next;
            master_address    <= cand_address;
            master_read       <= read_next;
            master_burstcount <= count_next;
            control_done      <= done_next;
            words             <= cand_words;
            fixed             <= cand_fixed;
            pending           <= pending_next;
            abort_req         <= abort_next;
        end
    end

    rm_showahead_fifo #(
        .WIDTH (DATAWIDTH),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (master_readdatavalid),
        .wdata (master_readdata),
        .rd    (user_read_buffer),
        .rdata (user_buffer_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .used  (fifo_used)
    );

endmodule

// File: tb/tb_burst_read_master.sv
// Directed bench for burst_read_master with a latency-3 burst slave model,
// a command/data scoreboard and a randomly popping user.
module tb_burst_read_master;

    logic        clk;
    logic        reset;
    logic        control_fixed_location;
    logic [31:0] control_read_base;
    logic [31:0] control_read_length;
    logic        control_go;
    logic        control_abort;
    logic        control_busy;
    logic        control_done;
    logic        user_read_buffer;
    logic [31:0] user_buffer_data;
    logic        user_data_available;
    logic [31:0] master_address;
    logic        master_read;
    logic [3:0]  master_byteenable;
    logic [3:0]  master_burstcount;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        master_waitrequest;

    burst_read_master #(
        .DATAWIDTH       (32),
        .BYTEENABLEWIDTH (4),
        .ADDRESSWIDTH    (32),
        .MAXBURST        (8),
        .MAXBURST_LOG2   (3),
        .FIFODEPTH       (64),
        .FIFODEPTH_LOG2  (6)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_read_base      (control_read_base),
        .control_read_length    (control_read_length),
        .control_go             (control_go),
        .control_abort          (control_abort),
        .control_busy           (control_busy),
        .control_done           (control_done),
        .user_read_buffer       (user_read_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_data_available    (user_data_available),
        .master_address         (master_address),
        .master_read            (master_read),
        .master_byteenable      (master_byteenable),
        .master_burstcount      (master_burstcount),
        .master_readdata        (master_readdata),
        .master_readdatavalid   (master_readdatavalid),
        .master_waitrequest     (master_waitrequest)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bench state ----------------
    int          checks     = 0;
    int          errors     = 0;
    int          cyc        = 0;
    int          done_count = 0;
    int          exp_done   = 0;
    int          acc_words  = 0;
    int          last_due   = 0;
    int          wait_mode  = 0;   // 0 no wait, 1 random, 2 always stall
    bit          auto_pop   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr;
    logic [3:0]  prev_cnt;

    logic [31:0] exp_q[$];
    logic [31:0] exp_cmd_addr_q[$];
    logic [3:0]  exp_cmd_cnt_q[$];
    logic [31:0] resp_data_q[$];
    int          resp_due_q[$];

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- slave driver (just after each rising edge) ----------------
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reset) begin
            resp_data_q.delete();
            resp_due_q.delete();
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
            master_waitrequest   = 1'b0;
        end else begin
            case (wait_mode)
                0:       master_waitrequest = 1'b0;
                1:       master_waitrequest = 1'($urandom_range(0, 1));
                default: master_waitrequest = 1'b1;
            endcase
            if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
                master_readdatavalid = 1'b1;
                master_readdata      = resp_data_q.pop_front();
                void'(resp_due_q.pop_front());
            end else begin
                master_readdatavalid = 1'b0;
                master_readdata      = $urandom;
            end
        end
    end

    // ---------------- monitor, scoreboard, user popper (falling edge) ----------------
    always @(negedge clk) begin
        if (reset) begin
            prev_stall       = 1'b0;
            user_read_buffer = 1'b0;
        end else begin
            if (control_done) done_count = done_count + 1;
            if (prev_stall) begin
                check("stall_read", 64'(master_read), 64'(1));
                check("stall_addr", 64'(master_address), 64'(prev_addr));
                check("stall_cnt", 64'(master_burstcount), 64'(prev_cnt));
            end
            prev_stall = master_read && master_waitrequest;
            prev_addr  = master_address;
            prev_cnt   = master_burstcount;
            if (master_read && !master_waitrequest) begin
                acc_words = acc_words + int'(master_burstcount);
                check("cmd_expected", 64'(exp_cmd_addr_q.size() > 0), 64'(1));
                if (exp_cmd_addr_q.size() > 0) begin
                    check("cmd_addr", 64'(master_address), 64'(exp_cmd_addr_q.pop_front()));
                    check("cmd_cnt", 64'(master_burstcount), 64'(exp_cmd_cnt_q.pop_front()));
                end
                // Acceptance happens at the next edge; data follows 3 cycles on.
                for (int k = 0; k < int'(master_burstcount); k++) begin
                    int due;
                    due = cyc + 3 + k;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    resp_due_q.push_back(due);
                    resp_data_q.push_back(data_of(master_address + 32'(4 * k)));
                end
            end
            if (auto_pop && user_data_available && $urandom_range(0, 3) != 0) begin
                check("data_expected", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    check("data", 64'(user_buffer_data), 64'(exp_q.pop_front()));
                end
                user_read_buffer = 1'b1;
            end else begin
                user_read_buffer = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_go(input logic [31:0] base, input logic [31:0] len,
                         input bit fix, input int max_cmds);
        logic [31:0] a;
        logic [31:0] w;
        int          n;
        int          first_n;
        int          ncmd;
        a       = base;
        w       = len >> 2;
        ncmd    = 0;
        first_n = 0;
        while (w > 0 && ncmd < max_cmds) begin
            if (fix) begin
                n = (w < 8) ? int'(w) : 8;
            end else begin
                n = 8 - int'((a >> 2) & 32'd7);
                if (w < 32'(n)) n = int'(w);
            end
            if (ncmd == 0) first_n = n;
            exp_cmd_addr_q.push_back(a);
            exp_cmd_cnt_q.push_back(4'(n));
            for (int k = 0; k < n; k++) exp_q.push_back(data_of(a + 32'(4 * k)));
            w = w - 32'(n);
            if (!fix) a = a + 32'(4 * n);
            ncmd = ncmd + 1;
        end
        acc_words = 0;
        @(posedge clk); #2;
        control_read_base      = base;
        control_read_length    = len;
        control_fixed_location = fix;
        control_go             = 1'b1;
        @(posedge clk); #2;
        control_go = 1'b0;
        if ((len >> 2) != 0) begin
            check("go_read", 64'(master_read), 64'(1));
            check("go_addr", 64'(master_address), 64'(base));
            check("go_cnt", 64'(master_burstcount), 64'(first_n));
        end
    endtask

    task automatic wait_done(input int budget);
        exp_done = exp_done + 1;
        for (int i = 0; i < budget && done_count < exp_done; i++) begin
            @(negedge clk); #1;
        end
        check("done_seen", 64'(done_count), 64'(exp_done));
        check("busy_low", 64'(control_busy), 64'(0));
    endtask

    task automatic wait_drained(input int budget);
        for (int i = 0; i < budget && (exp_q.size() > 0 || user_data_available); i++) begin
            @(negedge clk); #1;
        end
        repeat (4) @(negedge clk);
        #1;
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("cmd_q_empty", 64'(exp_cmd_addr_q.size()), 64'(0));
        check("fifo_empty", 64'(user_data_available), 64'(0));
        check("done_once", 64'(done_count), 64'(exp_done));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset                  = 1'b1;
        control_fixed_location = 1'b0;
        control_read_base      = '0;
        control_read_length    = '0;
        control_go             = 1'b0;
        control_abort          = 1'b0;
        user_read_buffer       = 1'b0;
        master_readdata        = '0;
        master_readdatavalid   = 1'b0;
        master_waitrequest     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_read", 64'(master_read), 64'(0));
        check("rst_addr", 64'(master_address), 64'(0));
        check("rst_cnt", 64'(master_burstcount), 64'(0));
        check("rst_busy", 64'(control_busy), 64'(0));
        check("rst_done", 64'(control_done), 64'(0));
        check("rst_avail", 64'(user_data_available), 64'(0));
        check("byteenable", 64'(master_byteenable), 64'(4'hF));
        @(negedge clk);
        reset = 1'b0;

        // Aligned two-burst read.
        auto_pop = 1'b1;
        do_go(32'h100, 32'd64, 1'b0, 99);
        wait_done(200);
        check("aligned_words", 64'(acc_words), 64'(16));
        wait_drained(200);

        // Misaligned start: short first burst, short remainder.
        do_go(32'h10C, 32'd40, 1'b0, 99);
        wait_done(200);
        check("misaligned_words", 64'(acc_words), 64'(10));
        wait_drained(200);

        // Zero-word length (sub-word bits ignored).
        do_go(32'h500, 32'd3, 1'b0, 99);
        check("zero_busy", 64'(control_busy), 64'(0));
        wait_done(10);
        check("zero_no_cmd", 64'(acc_words), 64'(0));
        wait_drained(20);

        // FIFO reservation: no pops, issuing must stop at 64 words.
        auto_pop = 1'b0;
        do_go(32'h1000, 32'd1024, 1'b0, 999);
        repeat (120) @(negedge clk);
        #1;
        check("hold_words", 64'(acc_words), 64'(64));
        check("hold_used", 64'(dut.fifo_used), 64'(64));
        check("hold_read", 64'(master_read), 64'(0));
        check("hold_busy", 64'(control_busy), 64'(1));
        check("hold_avail", 64'(user_data_available), 64'(1));
        auto_pop = 1'b1;
        wait_done(4000);
        check("hold_total", 64'(acc_words), 64'(256));
        wait_drained(400);

        // Fixed location with random stalls.
        wait_mode = 1;
        do_go(32'h2000, 32'd32, 1'b1, 99);
        wait_done(400);
        check("fixed_words", 64'(acc_words), 64'(8));
        wait_drained(200);
        do_go(32'h2004, 32'd40, 1'b1, 99);
        wait_done(400);
        check("fixed_misaligned_words", 64'(acc_words), 64'(10));
        wait_drained(200);

        // Abort while the second command is stalled.
        wait_mode = 2;
        do_go(32'h3000, 32'd256, 1'b0, 2);
        wait_mode = 0;
        @(posedge clk); #2;
        wait_mode = 2;
        @(posedge clk); #2;
        check("abort_second_cmd", 64'(master_read), 64'(1));
        control_abort = 1'b1;
        @(posedge clk); #2;
        control_abort = 1'b0;
        wait_mode     = 0;
        check("abort_hold_read", 64'(master_read), 64'(1));
        check("abort_hold_addr", 64'(master_address), 64'(32'h3020));
        wait_done(300);
        check("abort_words", 64'(acc_words), 64'(16));
        wait_drained(200);

        // Asynchronous reset in the middle of a transfer.
        auto_pop = 1'b0;
        do_go(32'h6000, 32'd1024, 1'b0, 999);
        for (int i = 0; i < 20 && !user_data_available; i++) begin
            @(negedge clk); #1;
        end
        check("pre_reset_read", 64'(master_read), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_read", 64'(master_read), 64'(0));
        check("mid_rst_addr", 64'(master_address), 64'(0));
        check("mid_rst_cnt", 64'(master_burstcount), 64'(0));
        check("mid_rst_busy", 64'(control_busy), 64'(0));
        check("mid_rst_done", 64'(control_done), 64'(0));
        check("mid_rst_avail", 64'(user_data_available), 64'(0));
        exp_q.delete();
        exp_cmd_addr_q.delete();
        exp_cmd_cnt_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        auto_pop = 1'b1;
        do_go(32'h100, 32'd64, 1'b0, 99);
        wait_done(200);
        check("post_reset_words", 64'(acc_words), 64'(16));
        wait_drained(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_read_master.md
# burst_read_master

Parametrised, burst-capable successor to the team's single-word latency-aware read master. It streams a byte-length region from an Avalon-MM slave into an internal show-ahead FIFO, issuing bursts of up to MAXBURST words. Bursts are aligned to MAXBURST boundaries, and the FIFO is reserved before each burst is issued. It sits between a memory interconnect and streaming user logic (DMA and filter front-ends), and adds abort and busy/done-pulse control.

## Interface
- DATAWIDTH, 32: data word width in bits
- BYTEENABLEWIDTH, 4: DATAWIDTH/8; bytes per word
- ADDRESSWIDTH, 32: byte-address and length width
- MAXBURST, 8: maximum burst length in words; power of 2, ≥1
- MAXBURST_LOG2, 3: log2(MAXBURST)
- FIFODEPTH, 64: FIFO words; power of 2, ≥ 2*MAXBURST
- FIFODEPTH_LOG2, 6: log2(FIFODEPTH)

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- control_fixed_location  in  1  sampled on accepted go; 1 = do not increment address
- control_read_base  in  ADDRESSWIDTH  word-aligned start byte address
- control_read_length  in  ADDRESSWIDTH  bytes to read; low log2(BYTEENABLEWIDTH) bits ignored
- control_go  in  1  start pulse; honoured only in IDLE
- control_abort  in  1  stop issuing new bursts
- control_busy  out  1  high in any state other than IDLE
- control_done  out  1  one-cycle pulse on return to IDLE
- user_read_buffer  in  1  pop FIFO head; ignored when empty
- user_buffer_data  out  DATAWIDTH  FIFO head (show-ahead)
- user_data_available  out  1  FIFO not empty
- master_address  out  ADDRESSWIDTH  burst start byte address
- master_read  out  1  read command valid
- master_byteenable  out  BYTEENABLEWIDTH  constant all-ones
- master_burstcount  out  MAXBURST_LOG2+1  words in current burst, 1..MAXBURST
- master_readdata  in  DATAWIDTH  returned word
- master_readdatavalid  in  1  master_readdata valid; written into the FIFO unconditionally
- master_waitrequest  in  1  slave stall

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE, on go:
  - latch address ← base, words ← length>>log2(BYTEENABLEWIDTH), fixed ← control_fixed_location.
  - If words = 0: stay in IDLE, pulse control_done next cycle.
  - Otherwise: enter ISSUE.
- Burst size:
  - Normal mode: burst = min(MAXBURST − (address/BYTEENABLEWIDTH mod MAXBURST), words). Only the first burst may be short for alignment; the last burst may be short for the remainder.
  - Fixed mode: burst = min(MAXBURST, words).
- Space check: present a command only when fifo_used + pending + burst ≤ FIFODEPTH. pending counts words accepted but not yet returned, width FIFODEPTH_LOG2+1.
- Command acceptance (read & !waitrequest):
  - words −= burst; pending += burst.
  - address += burst*BYTEENABLEWIDTH, unless fixed.
- Each master_readdatavalid: pending −= 1. If acceptance and readdatavalid coincide, pending += burst − 1.
- ISSUE → DRAIN when words reaches 0, or when abort is seen with no command outstanding.
- Abort while a command is presented and stalled: keep that command stable until it is accepted, then enter DRAIN.
- DRAIN → IDLE when pending = 0. Pulse control_done on that transition.
- Returned data always enters the FIFO; abort never discards data. Overflow cannot occur by construction.
- go outside IDLE is ignored. Abort in IDLE is ignored.

## Timing
- Reset values (async): master_read 0, master_address 0, master_burstcount 0, control_busy 0, control_done 0, user_data_available 0. pending, words and the FIFO are cleared.
- Reset mid-transfer returns the block to IDLE immediately. Data still in flight from the slave is the system's responsibility.
- All master_* outputs are registered. Accepted go at edge N → master_read high during cycle N+1.
- While master_read & waitrequest: master_address and master_burstcount are held stable.
- After an acceptance, the next command may be presented in the following cycle (back-to-back bursts) if space allows.
- FIFO write at edge N → user_data_available high and word on user_buffer_data in cycle N+1.
- Simultaneous push and pop are allowed at any fill level, including empty-with-push (no bypass) and full-with-pop.
- Length arithmetic is unsigned modulo 2^ADDRESSWIDTH. Address wrap-around is permitted and not flagged.

## Structure
- Shared package `burst_read_master_pkg`: state enum (IDLE/ISSUE/DRAIN) and a function `clog2`. Parameters are checked at elaboration.
- Sub-module `rm_showahead_fifo`:
  - parameters: width and depth.
  - ports: clk, reset, wr, wdata, rd, rdata, empty, full, used.
  - used is FIFODEPTH_LOG2+1 bits so the full count is representable.

## Test plan
- Base 0x100, length 64, MAXBURST 8, zero-wait slave with 3-cycle latency → two bursts: address 0x100 count 8, then 0x120 count 8. 16 words in order; one done pulse.
- Base 0x10C, length 40 → bursts of 5 (at 0x10C) and 5 (at 0x120). Check alignment and the remainder burst.
- User never pops, length 1024 → issuing stops once fifo_used + pending reaches 64. Exactly 64 words are stored with no overflow. Issuing resumes after pops.
- Random waitrequest, fixed_location 1, length 32 → every command is at base address and master_address/master_burstcount stay stable during stalls. 8 words are returned.
- Abort asserted after the first acceptance of a 256-byte read → no further commands are issued. Outstanding words are drained into the FIFO, then one done pulse and control_busy falls.
- Reset asserted mid-burst → all outputs take their reset values in the same cycle. A new go afterwards runs cleanly.
